// File: rtl/fetch_pkg.sv
// Shared widths, reset default and the buffered-instruction record for the
// instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int XLEN   = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 16'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   word;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: ROM read port, instruction stream and redirect request.
interface fetch_if;
    import fetch_pkg::*;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [XLEN-1:0]   rom_dout;

    logic              instr_valid;
    logic              instr_ready;
    logic [XLEN-1:0]   instr;
    logic [ADDR_W-1:0] instr_pc;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output rom_ce, rom_addr,
        input  rom_dout,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  rom_ce, rom_addr,
        output rom_dout,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with push, pop and flush; head is the oldest entry.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entry_q [2];
    fetch_entry_t entry_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        // NOTE: every *_d gets its default first so no path can infer a latch.
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = push_data;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two entries are reset as well, so head reads zero during reset.
            entry_q  <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every flop sees pre-edge values.
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = entry_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch from a synchronous ROM into a two-entry buffer,
// with redirect (flush + squash) and occupancy-based issue throttling.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    fetch_if.master bus
);

    localparam logic [2:0] MAX_OCC = 3'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        fifo_count;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_entry;
    logic              instr_valid;
    logic              transfer;
    logic              issue;
    logic              push;
    logic [2:0]        occupancy;

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (transfer),
        .flush     (bus.redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        instr_valid = (fifo_count != 2'd0) && !bus.redirect_valid;
        transfer    = instr_valid && bus.instr_ready;
        occupancy   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, transfer};
        // rst gates issue directly so rom_ce is low for the whole asynchronous reset.
        issue       = !rst && !bus.redirect_valid && (occupancy < MAX_OCC);
        // A redirect squashes the word returning this cycle.
        push        = inflight_q && !bus.redirect_valid;

        push_entry.pc   = last_addr_q;
        push_entry.word = bus.rom_dout;

        fetch_pc_d  = fetch_pc_q;
        last_addr_d = last_addr_q;
        inflight_d  = issue;
        if (bus.redirect_valid) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d  = fetch_pc_q + PC_STEP;
            last_addr_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            last_addr_q <= RESET_PC;
            inflight_q  <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
        end
    end

    // last_addr_q doubles as the pc of the inflight word.
    assign bus.rom_ce      = issue;
    assign bus.rom_addr    = issue ? fetch_pc_q : last_addr_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = fifo_head.word;
    assign bus.instr_pc    = fifo_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus queues expected
// {pc, word} pairs, monitors compare every handshake against them.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    fetch_if bus0 ();
    fetch_if bus1 ();

    instr_fetch_unit dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    instr_fetch_unit #(
        .RESET_PC   (16'hFFF8),
        .FIFO_DEPTH (2)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    int checks   = 0;
    int failures = 0;

    fetch_entry_t exp0_q [$];
    fetch_entry_t exp1_q [$];

    // ROM[0..3] = 11,22,33,44; elsewhere a pattern tagged with the address.
    function automatic logic [31:0] rom_word(input logic [15:0] addr);
        case (addr[15:2])
            14'd0:   return 32'h11;
            14'd1:   return 32'h22;
            14'd2:   return 32'h33;
            14'd3:   return 32'h44;
            default: return {16'hC0DE, addr};
        endcase
    endfunction

    always @(posedge clk) if (bus0.rom_ce) bus0.rom_dout <= rom_word(bus0.rom_addr);
    always @(posedge clk) if (bus1.rom_ce) bus1.rom_dout <= rom_word(bus1.rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect0(input logic [15:0] pc, input logic [31:0] word);
        fetch_entry_t e;
        e.pc   = pc;
        e.word = word;
        exp0_q.push_back(e);
    endtask

    task automatic expect1(input logic [15:0] pc, input logic [31:0] word);
        fetch_entry_t e;
        e.pc   = pc;
        e.word = word;
        exp1_q.push_back(e);
    endtask

    // Monitor for dut0: scoreboard compare on handshake, plus hold stability.
    initial begin
        fetch_entry_t e;
        logic         hold;
        logic [15:0]  held_pc;
        logic [31:0]  held_instr;
        hold       = 1'b0;
        held_pc    = '0;
        held_instr = '0;
        forever begin
            @(negedge clk);
            if (bus0.instr_valid === 1'b1 && bus0.instr_ready === 1'b1) begin
                if (exp0_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut0 unexpected transfer: got pc=%h instr=%h expected none",
                             bus0.instr_pc, bus0.instr);
                end else begin
                    e = exp0_q.pop_front();
                    check("dut0 instr_pc", 32'(bus0.instr_pc), 32'(e.pc));
                    check("dut0 instr", bus0.instr, e.word);
                end
            end
            if (hold && bus0.instr_valid === 1'b1) begin
                check("dut0 stable instr_pc", 32'(bus0.instr_pc), 32'(held_pc));
                check("dut0 stable instr", bus0.instr, held_instr);
            end
            hold       = (bus0.instr_valid === 1'b1) && (bus0.instr_ready === 1'b0);
            held_pc    = bus0.instr_pc;
            held_instr = bus0.instr;
        end
    end

    // Monitor for dut1.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (bus1.instr_valid === 1'b1 && bus1.instr_ready === 1'b1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut1 unexpected transfer: got pc=%h instr=%h expected none",
                             bus1.instr_pc, bus1.instr);
                end else begin
                    e = exp1_q.pop_front();
                    check("dut1 instr_pc", 32'(bus1.instr_pc), 32'(e.pc));
                    check("dut1 instr", bus1.instr, e.word);
                end
            end
        end
    end

    // One cycle of dut0 stimulus: drive after the edge, return at the falling edge.
    task automatic drive0(input logic rdy, input logic rv, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        bus0.instr_ready    = rdy;
        bus0.redirect_valid = rv;
        bus0.redirect_pc    = rpc;
        @(negedge clk);
    endtask

    task automatic release0(input logic rdy);
        @(posedge clk);
        #1;
        rst                 = 1'b0;
        bus0.instr_ready    = rdy;
        bus0.redirect_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset0(input string tag);
        check({tag, " rom_ce"},      32'(bus0.rom_ce),      32'd0);
        check({tag, " rom_addr"},    32'(bus0.rom_addr),    32'h0000);
        check({tag, " instr_valid"}, 32'(bus0.instr_valid), 32'd0);
        check({tag, " instr"},       bus0.instr,            32'd0);
        check({tag, " instr_pc"},    32'(bus0.instr_pc),    32'h0000);
    endtask

    // Assert reset mid-cycle and check outputs before any clock edge.
    task automatic reset0(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset0(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int issues;
        bus0.instr_ready    = 1'b0;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc    = '0;
        bus1.instr_ready    = 1'b0;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset0("reset");
        check("reset dut1 rom_addr", 32'(bus1.rom_addr), 32'h0000FFF8);
        check("reset dut1 rom_ce",   32'(bus1.rom_ce),   32'd0);

        // A: streaming with ready held high
        expect0(16'h0000, 32'h11);
        expect0(16'h0004, 32'h22);
        expect0(16'h0008, 32'h33);
        expect0(16'h000C, 32'h44);
        release0(1'b1);
        check("A first issue rom_ce",   32'(bus0.rom_ce),      32'd1);
        check("A first issue rom_addr", 32'(bus0.rom_addr),    32'h0000);
        check("A cycle0 instr_valid",   32'(bus0.instr_valid), 32'd0);
        drive0(1'b1, 1'b0, 16'h0);
        check("A cycle1 instr_valid",   32'(bus0.instr_valid), 32'd0);
        check("A cycle1 rom_addr",      32'(bus0.rom_addr),    32'h0004);
        drive0(1'b1, 1'b0, 16'h0);
        check("A first instr_valid",    32'(bus0.instr_valid), 32'd1);
        repeat (3) drive0(1'b1, 1'b0, 16'h0);
        drive0(1'b0, 1'b0, 16'h0);
        check("A all delivered", 32'(exp0_q.size()), 32'd0);
        reset0("A mid-run reset");

        // B: stall five cycles after first valid, then release
        expect0(16'h0000, 32'h11);
        expect0(16'h0004, 32'h22);
        expect0(16'h0008, 32'h33);
        issues = 0;
        release0(1'b0);
        issues += int'(bus0.rom_ce);
        drive0(1'b0, 1'b0, 16'h0);
        issues += int'(bus0.rom_ce);
        repeat (5) begin
            drive0(1'b0, 1'b0, 16'h0);
            issues += int'(bus0.rom_ce);
        end
        check("B issues during stall", 32'(issues), 32'd2);
        check("B held instr_valid",    32'(bus0.instr_valid), 32'd1);
        check("B held instr",          bus0.instr,            32'h11);
        check("B held instr_pc",       32'(bus0.instr_pc),    32'h0000);
        repeat (3) begin
            drive0(1'b1, 1'b0, 16'h0);
            check("B back-to-back instr_valid", 32'(bus0.instr_valid), 32'd1);
        end
        drive0(1'b0, 1'b0, 16'h0);
        drive0(1'b0, 1'b0, 16'h0);
        check("B all delivered",      32'(exp0_q.size()),   32'd0);
        check("B full head instr_pc", 32'(bus0.instr_pc),   32'h000C);
        check("B full head instr",    bus0.instr,           32'h44);
        reset0("B full-FIFO reset");

        // C: redirect to 0x0102 with one buffered and one inflight word
        expect0(16'h0100, 32'hC0DE0100);
        expect0(16'h0104, 32'hC0DE0104);
        release0(1'b0);
        check("C restart rom_ce",      32'(bus0.rom_ce),      32'd1);
        check("C restart rom_addr",    32'(bus0.rom_addr),    32'h0000);
        check("C no stale valid",      32'(bus0.instr_valid), 32'd0);
        drive0(1'b0, 1'b0, 16'h0);
        check("C cycle1 instr_valid",  32'(bus0.instr_valid), 32'd0);
        drive0(1'b0, 1'b1, 16'h0102);
        check("C redirect instr_valid", 32'(bus0.instr_valid), 32'd0);
        check("C redirect rom_ce",      32'(bus0.rom_ce),      32'd0);
        check("C redirect rom_addr",    32'(bus0.rom_addr),    32'h0004);
        drive0(1'b0, 1'b0, 16'h0);
        check("C post-redirect rom_ce",   32'(bus0.rom_ce),      32'd1);
        check("C post-redirect rom_addr", 32'(bus0.rom_addr),    32'h0100);
        check("C post-redirect valid",    32'(bus0.instr_valid), 32'd0);
        drive0(1'b0, 1'b0, 16'h0);
        check("C redirect+1 valid",       32'(bus0.instr_valid), 32'd0);
        drive0(1'b1, 1'b0, 16'h0);
        check("C redirect+2 valid",       32'(bus0.instr_valid), 32'd1);
        drive0(1'b1, 1'b0, 16'h0);
        drive0(1'b0, 1'b0, 16'h0);

        // D: redirect in the same cycle as ready, FIFO full (head 0x108)
        expect0(16'h0200, 32'hC0DE0200);
        drive0(1'b1, 1'b1, 16'h0203);
        check("D redirect+ready valid", 32'(bus0.instr_valid), 32'd0);
        drive0(1'b1, 1'b0, 16'h0);
        check("D restart rom_ce",       32'(bus0.rom_ce),      32'd1);
        check("D restart rom_addr",     32'(bus0.rom_addr),    32'h0200);
        check("D restart valid",        32'(bus0.instr_valid), 32'd0);
        drive0(1'b1, 1'b0, 16'h0);
        check("D redirect+1 valid",     32'(bus0.instr_valid), 32'd0);
        drive0(1'b1, 1'b0, 16'h0);
        check("D redirect+2 valid",     32'(bus0.instr_valid), 32'd1);
        drive0(1'b0, 1'b0, 16'h0);
        #1;
        check("CD all delivered", 32'(exp0_q.size()), 32'd0);
        reset0("D reset");

        // E: RESET_PC = 0xFFF8 wraps through 0x0000
        expect1(16'hFFF8, 32'hC0DEFFF8);
        expect1(16'hFFFC, 32'hC0DEFFFC);
        expect1(16'h0000, 32'h11);
        expect1(16'h0004, 32'h22);
        @(posedge clk);
        #1;
        rst1             = 1'b0;
        bus1.instr_ready = 1'b1;
        @(negedge clk);
        check("E first issue rom_ce",   32'(bus1.rom_ce),   32'd1);
        check("E first issue rom_addr", 32'(bus1.rom_addr), 32'h0000FFF8);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        bus1.instr_ready = 1'b0;
        @(negedge clk);
        check("E all delivered", 32'(exp1_q.size()), 32'd0);
        rst1 = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
